mem_xfer_sequencer: RTL and testbench
=====================================

// Module: mem_xfer_sequencer
// PURPOSE
//  Parametrised phase sequencer for the two-memory datapath (RAM A, RAM B).
//  Generates the write-enable and address-increment strobes for memories A and B.
//  Tracks the A and B address pointers.
//  Sequence: load A, wait a gap, interleave writes into B with pointer steps, drain B.
//  Adds a start/busy/done handshake, a stall input and optional auto-restart.
// PARAMETERS
//  DEPTH_A      8  number of words written into A in LOAD_A (>=1)
//  GAP_CYC      2  idle cycles between LOAD_A and XFER (>=0; 0 skips GAP)
//  XFER_CNT     4  number of write/step pairs in XFER (>=1)
//  DRAIN_CNT    4  IncB-only cycles in DRAIN (>=0; 0 skips DRAIN)
//  ADDR_W       4  width of addr_a/addr_b
//  AUTO_RESTART 0  1: IDLE->LOAD_A without start (free-running); 0: wait for start
// PORTS
//  clk      in   1       rising-edge clock
//  Reset    in   1       asynchronous, active-high reset
//  start    in   1       level, sampled in IDLE only
//  stall    in   1       freeze sequence, strobes forced 0
//  WEA      out  1       write enable, memory A
//  IncA     out  1       increment A address pointer
//  WEB      out  1       write enable, memory B
//  IncB     out  1       increment B address pointer
//  addr_a   out  ADDR_W  A pointer
//  addr_b   out  ADDR_W  B pointer
//  busy     out  1       1 in every state except IDLE
//  done     out  1       1-cycle pulse in DONE state
//  phase    out  3       state code: IDLE=0 LOAD_A=1 GAP=2 XFER_W=3 XFER_I=4 DRAIN=5 DONE=6
// BEHAVIOUR
//  - Reset (async) -> IDLE; phase counter=0, addr_a=addr_b=0; all strobes, busy, done = 0.
//  - Reset applied mid-sequence aborts immediately to the same state. No done pulse.
//  - Outputs are Moore, decoded from registered state.
//  - stall gates WEA/IncA/WEB/IncB combinationally. It is the only input-to-output path.
//  - IDLE: all strobes 0.
//    If start=1 (or AUTO_RESTART=1), the next edge -> LOAD_A and clears addr_a/addr_b to 0.
//  - LOAD_A: DEPTH_A cycles with WEA=1 and IncA=1. Then -> GAP (or XFER_W if GAP_CYC=0).
//  - GAP: GAP_CYC cycles, all strobes 0. Then -> XFER_W.
//  - XFER_W: WEB=1, one cycle -> XFER_I.
//  - XFER_I: IncB=1, one cycle.
//    -> XFER_W if fewer than XFER_CNT pairs have completed.
//    -> otherwise DRAIN, or DONE if DRAIN_CNT=0.
//  - DRAIN: DRAIN_CNT cycles with IncB=1. Then -> DONE.
//  - DONE: done=1 for one cycle, busy=1. Then -> IDLE.
//    With AUTO_RESTART=1, IDLE lasts exactly one cycle.
//  - Pointer update: addr_a += 1 on each cycle with ungated IncA=1 and stall=0.
//    addr_b likewise with IncB. Both wrap mod 2**ADDR_W with no flag.
//  - stall=1 in any non-IDLE state:
//    - state, phase counter, pair counter and pointers hold;
//    - strobes = 0 and busy stays 1.
//    The sequence resumes exactly where it stopped; no cycle is lost or duplicated.
//    stall in IDLE has no effect. start is still honoured.
//  - start while busy is ignored; it is not queued.
//    start=1 held continuously with AUTO_RESTART=0 gives back-to-back runs.
//  - Latency, with start sampled at edge k:
//    - first WEA appears in cycle k+1;
//    - done appears in cycle k + DEPTH_A + GAP_CYC + 2*XFER_CNT + DRAIN_CNT + 1
//      (defaults: k+23);
//    - every stalled cycle adds one cycle.
//  - Phase counter width = $clog2 of the largest phase length, minimum 1.
//    Illegal parameter values are rejected at elaboration ($error).
// TESTING
//  1. Defaults, one-cycle start at edge 0.
//     Expect: WEA=IncA=1 in cycles 1-8; GAP in cycles 9-10; WEB=1 in cycles 11,13,15,17;
//     IncB=1 in cycles 12,14,16,18-22; done=1 in cycle 23; busy low from cycle 24.
//  2. Pointers after test 1 completes: addr_a=8, addr_b=8.
//     With ADDR_W=3 the same run ends with addr_a=0, addr_b=0 (wrap).
//  3. stall=1 for 3 cycles during the 5th LOAD_A cycle.
//     Expect: WEA/IncA=0 while stalled, addr_a held at 4; done at cycle 26; totals unchanged.
//  4. Assert Reset during XFER_I, then release it.
//     Expect: all outputs 0 and phase=0 immediately; no done pulse;
//     a fresh start runs the full test-1 sequence.
//  5. start pulsed during DRAIN.
//     Expect: ignored; exactly one done. AUTO_RESTART=1 with start=0 runs continuously:
//     done every 24 cycles.
//  6. GAP_CYC=0, DRAIN_CNT=0, XFER_CNT=1, DEPTH_A=1.
//     Expect: WEA in cycle 1, WEB in cycle 2, IncB in cycle 3, done in cycle 4.

Source files
------------

// File: rtl/mem_xfer_sequencer.sv
// Phase sequencer for the RAM A / RAM B datapath: loads A, waits a gap,
// interleaves B writes with B pointer steps, then drains B. Tracks both
// address pointers and offers a start/busy/done handshake with stall support.
module mem_xfer_sequencer #(
    parameter int DEPTH_A      = 8,
    parameter int GAP_CYC      = 2,
    parameter int XFER_CNT     = 4,
    parameter int DRAIN_CNT    = 4,
    parameter int ADDR_W       = 4,
    parameter int AUTO_RESTART = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              stall,
    output logic              WEA,
    output logic              IncA,
    output logic              WEB,
    output logic              IncB,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase
);

    // Reject parameter values the sequence cannot honour.
    generate
        if ((DEPTH_A < 1) || (GAP_CYC < 0) || (XFER_CNT < 1) || (DRAIN_CNT < 0) ||
            (ADDR_W < 1) || ((AUTO_RESTART != 0) && (AUTO_RESTART != 1))) begin : g_param_check
            $error("mem_xfer_sequencer: illegal parameter value");
        end
    endgenerate

    // Counter width sized to the longest phase (pair count included).
    localparam int MAX_AG  = (DEPTH_A > GAP_CYC) ? DEPTH_A : GAP_CYC;
    localparam int MAX_XD  = (XFER_CNT > DRAIN_CNT) ? XFER_CNT : DRAIN_CNT;
    localparam int MAX_LEN = (MAX_AG > MAX_XD) ? MAX_AG : MAX_XD;
    localparam int unsigned CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Terminal counts; zero-length phases are skipped so their value is unused.
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(DEPTH_A - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PAIR_LAST  = CNT_W'(XFER_CNT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CNT > 0) ? DRAIN_CNT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_GAP    = 3'd2,
        S_XFER_W = 3'd3,
        S_XFER_I = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Successor states for phases that may be configured away.
    localparam state_t AFTER_LOAD = (GAP_CYC > 0)   ? S_GAP   : S_XFER_W;
    localparam state_t AFTER_XFER = (DRAIN_CNT > 0) ? S_DRAIN : S_DONE;

    // Output flag vector layout: {wea, inca, web, incb, busy, done}.
    localparam int unsigned F_WEA  = 5;
    localparam int unsigned F_INCA = 4;
    localparam int unsigned F_WEB  = 3;
    localparam int unsigned F_INCB = 2;
    localparam int unsigned F_BUSY = 1;
    localparam int unsigned F_DONE = 0;

    state_t             state_q;
    logic [5:0]         flags_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   pair_q;
    logic [ADDR_W-1:0]  addr_a_q;
    logic [ADDR_W-1:0]  addr_b_q;
    logic               frozen;

    // Moore decode of the flags a state presents; loaded together with the state.
    function automatic logic [5:0] state_flags(input state_t s);
        logic [5:0] f;
        f = 6'b000000;
        case (s)
            S_LOAD_A: f = 6'b110010;
            S_GAP:    f = 6'b000010;
            S_XFER_W: f = 6'b001010;
            S_XFER_I: f = 6'b000110;
            S_DRAIN:  f = 6'b000110;
            S_DONE:   f = 6'b000011;
            default:  f = 6'b000000;
        endcase
        return f;
    endfunction

    // A stall freezes everything except in IDLE, where start is still honoured.
    assign frozen = stall && (state_q != S_IDLE);

    // Sequencer: state, registered output flags, phase/pair counters and pointers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            flags_q  <= 6'b000000;
            cnt_q    <= '0;
            pair_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else if (!frozen) begin
            case (state_q)
                S_IDLE: begin
                    if (start || (AUTO_RESTART != 0)) begin
                        state_q  <= S_LOAD_A;
                        flags_q  <= state_flags(S_LOAD_A);
                        cnt_q    <= '0;
                        pair_q   <= '0;
                        addr_a_q <= '0;
                        addr_b_q <= '0;
                    end
                end

                S_LOAD_A: begin
                    addr_a_q <= addr_a_q + ADDR_W'(1);
                    if (cnt_q == LOAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= AFTER_LOAD;
                        flags_q <= state_flags(AFTER_LOAD);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_XFER_W;
                        flags_q <= state_flags(S_XFER_W);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_XFER_W: begin
                    state_q <= S_XFER_I;
                    flags_q <= state_flags(S_XFER_I);
                end

                S_XFER_I: begin
                    addr_b_q <= addr_b_q + ADDR_W'(1);
                    if (pair_q == PAIR_LAST) begin
                        pair_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= AFTER_XFER;
                        flags_q <= state_flags(AFTER_XFER);
                    end else begin
                        pair_q  <= pair_q + CNT_W'(1);
                        state_q <= S_XFER_W;
                        flags_q <= state_flags(S_XFER_W);
                    end
                end

                S_DRAIN: begin
                    addr_b_q <= addr_b_q + ADDR_W'(1);
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        flags_q <= state_flags(S_DONE);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    flags_q <= state_flags(S_IDLE);
                end

                default: begin
                    state_q <= S_IDLE;
                    flags_q <= 6'b000000;
                    cnt_q   <= '0;
                    pair_q  <= '0;
                end
            endcase
        end
    end

    // Strobes are the registered flags gated by stall; the rest come straight from flops.
    assign WEA    = flags_q[F_WEA]  & ~stall;
    assign IncA   = flags_q[F_INCA] & ~stall;
    assign WEB    = flags_q[F_WEB]  & ~stall;
    assign IncB   = flags_q[F_INCB] & ~stall;
    assign busy   = flags_q[F_BUSY];
    assign done   = flags_q[F_DONE];
    assign phase  = state_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Directed bench for mem_xfer_sequencer: default run, stall, mid-run reset,
// ignored start, back-to-back, address wrap, auto-restart and minimal config.
module tb_mem_xfer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset, start, stall;
    logic       start_m, stall_m, start_ar, stall_ar;

    // Default-parameter instance.
    logic       WEA, IncA, WEB, IncB, busy, done;
    logic [3:0] addr_a, addr_b;
    logic [2:0] phase;

    // ADDR_W=3 instance driven alongside the default one.
    logic       w3_wea, w3_inca, w3_web, w3_incb, w3_busy, w3_done;
    logic [2:0] w3_addr_a, w3_addr_b;
    logic [2:0] w3_phase;

    // Auto-restart instance.
    logic       ar_wea, ar_inca, ar_web, ar_incb, ar_busy, ar_done;
    logic [3:0] ar_addr_a, ar_addr_b;
    logic [2:0] ar_phase;

    // Minimal configuration instance.
    logic       m_wea, m_inca, m_web, m_incb, m_busy, m_done;
    logic [3:0] m_addr_a, m_addr_b;
    logic [2:0] m_phase;

    mem_xfer_sequencer u_dut (
        .clk(clk), .Reset(Reset), .start(start), .stall(stall),
        .WEA(WEA), .IncA(IncA), .WEB(WEB), .IncB(IncB),
        .addr_a(addr_a), .addr_b(addr_b), .busy(busy), .done(done), .phase(phase)
    );

    mem_xfer_sequencer #(.ADDR_W(3)) u_w3 (
        .clk(clk), .Reset(Reset), .start(start), .stall(stall),
        .WEA(w3_wea), .IncA(w3_inca), .WEB(w3_web), .IncB(w3_incb),
        .addr_a(w3_addr_a), .addr_b(w3_addr_b), .busy(w3_busy), .done(w3_done), .phase(w3_phase)
    );

    mem_xfer_sequencer #(.AUTO_RESTART(1)) u_ar (
        .clk(clk), .Reset(Reset), .start(start_ar), .stall(stall_ar),
        .WEA(ar_wea), .IncA(ar_inca), .WEB(ar_web), .IncB(ar_incb),
        .addr_a(ar_addr_a), .addr_b(ar_addr_b), .busy(ar_busy), .done(ar_done), .phase(ar_phase)
    );

    mem_xfer_sequencer #(.DEPTH_A(1), .GAP_CYC(0), .XFER_CNT(1), .DRAIN_CNT(0)) u_min (
        .clk(clk), .Reset(Reset), .start(start_m), .stall(stall_m),
        .WEA(m_wea), .IncA(m_inca), .WEB(m_web), .IncB(m_incb),
        .addr_a(m_addr_a), .addr_b(m_addr_b), .busy(m_busy), .done(m_done), .phase(m_phase)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Default-parameter timeline, cycle e counted from the edge that samples start.
    function automatic int ref_phase(input int e);
        if (e >= 1  && e <= 8)  return 1;
        if (e >= 9  && e <= 10) return 2;
        if (e >= 11 && e <= 18) return (e % 2 == 1) ? 3 : 4;
        if (e >= 19 && e <= 22) return 5;
        if (e == 23)            return 6;
        return 0;
    endfunction

    // Pointer value seen in cycle e: number of stepping cycles before it.
    function automatic int ref_ptr(input int e, input bit for_b);
        int n = 0;
        for (int j = 1; j < e; j++) begin
            if (!for_b && ref_phase(j) == 1) n++;
            if (for_b && (ref_phase(j) == 4 || ref_phase(j) == 5)) n++;
        end
        return n;
    endfunction

    // One run of the default instance: start at cycle 0, optional stall window and extra start.
    task automatic run_main(input int s, input int l, input int extra, input int n);
        int e, ph, ea, eb;
        bit stl;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == extra);
            stall = (l > 0) && (c >= s) && (c < s + l);
            #1;
            stl = 1'b0;
            if (l == 0 || c < s)  e = c;
            else if (c < s + l) begin e = s; stl = 1'b1; end
            else                  e = c - l;
            ph = ref_phase(e);
            check($sformatf("c%0d phase", c), 32'(phase), 32'(ph));
            check($sformatf("c%0d WEA",   c), 32'(WEA),   32'(!stl && ph == 1));
            check($sformatf("c%0d IncA",  c), 32'(IncA),  32'(!stl && ph == 1));
            check($sformatf("c%0d WEB",   c), 32'(WEB),   32'(!stl && ph == 3));
            check($sformatf("c%0d IncB",  c), 32'(IncB),  32'(!stl && (ph == 4 || ph == 5)));
            check($sformatf("c%0d busy",  c), 32'(busy),  32'(ph != 0));
            check($sformatf("c%0d done",  c), 32'(done),  32'(ph == 6));
            if (done) done_seen++;
            if (e >= 1) begin
                ea = ref_ptr(e, 1'b0);
                eb = ref_ptr(e, 1'b1);
                check($sformatf("c%0d addr_a", c), 32'(addr_a), 32'(ea));
                check($sformatf("c%0d addr_b", c), 32'(addr_b), 32'(eb));
                check($sformatf("c%0d w3_addr_a", c), 32'(w3_addr_a), 32'(ea % 8));
                check($sformatf("c%0d w3_addr_b", c), 32'(w3_addr_b), 32'(eb % 8));
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int t[3];
        int nd;
        int d1, d2;
        int exp_ph[7];

        Reset = 1'b1; start = 1'b0; stall = 1'b0;
        start_m = 1'b0; stall_m = 1'b0; start_ar = 1'b0; stall_ar = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst phase",  32'(phase),  32'd0);
        check("rst busy",   32'(busy),   32'd0);
        check("rst done",   32'(done),   32'd0);
        check("rst WEA",    32'(WEA),    32'd0);
        check("rst IncB",   32'(IncB),   32'd0);
        check("rst addr_a", 32'(addr_a), 32'd0);
        check("rst addr_b", 32'(addr_b), 32'd0);
        Reset = 1'b0;

        // Default sequence, then pointer totals (including ADDR_W=3 wrap).
        run_main(0, 0, -1, 28);
        check("t1 addr_a end",    32'(addr_a),    32'd8);
        check("t1 addr_b end",    32'(addr_b),    32'd8);
        check("t2 w3 addr_a end", 32'(w3_addr_a), 32'd0);
        check("t2 w3 addr_b end", 32'(w3_addr_b), 32'd0);

        // Three-cycle stall during the fifth LOAD_A cycle; done moves to cycle 26.
        run_main(5, 3, -1, 31);
        check("t3 addr_a end", 32'(addr_a), 32'd8);
        check("t3 addr_b end", 32'(addr_b), 32'd8);

        // Reset during XFER_I aborts at once with no done pulse.
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            #1;
        end
        start = 1'b0;
        check("t4 pre phase", 32'(phase), 32'd4);
        Reset = 1'b1;
        #1;
        check("t4 phase",  32'(phase),  32'd0);
        check("t4 busy",   32'(busy),   32'd0);
        check("t4 done",   32'(done),   32'd0);
        check("t4 WEA",    32'(WEA),    32'd0);
        check("t4 IncA",   32'(IncA),   32'd0);
        check("t4 WEB",    32'(WEB),    32'd0);
        check("t4 IncB",   32'(IncB),   32'd0);
        check("t4 addr_a", 32'(addr_a), 32'd0);
        check("t4 addr_b", 32'(addr_b), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #2;
            if (done || busy) nd++;
        end
        check("t4 quiet after reset", 32'(nd), 32'd0);
        run_main(0, 0, -1, 28);

        // start pulsed during DRAIN is ignored: exactly one done.
        done_seen = 0;
        run_main(0, 0, 20, 30);
        check("t5 done count", 32'(done_seen), 32'd1);

        // start held high: back-to-back runs with one IDLE cycle between.
        d1 = -1; d2 = -1;
        for (int c = 0; c < 56; c++) begin
            @(posedge clk); #1;
            start = (c <= 30);
            #1;
            if (c == 24) check("t5 b2b idle busy", 32'(busy), 32'd0);
            if (done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        start = 1'b0;
        check("t5 b2b done1", 32'(d1), 32'd23);
        check("t5 b2b done2", 32'(d2), 32'd47);
        check("t5 b2b idle",  32'(busy), 32'd0);

        // Auto-restart: done every 24 cycles, IDLE for a single cycle.
        t[0] = -1; t[1] = -1; t[2] = -1;
        nd = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (t[0] >= 0 && c == t[0] + 1) check("ar idle phase", 32'(ar_phase), 32'd0);
            if (t[0] >= 0 && c == t[0] + 2) check("ar reload phase", 32'(ar_phase), 32'd1);
            if (ar_done && nd < 3) begin
                t[nd] = c;
                nd++;
            end
        end
        check("ar dones seen", 32'(nd), 32'd3);
        check("ar period 1", 32'(t[1] - t[0]), 32'd24);
        check("ar period 2", 32'(t[2] - t[1]), 32'd24);

        // Minimal configuration: WEA c1, WEB c2, IncB c3, done c4.
        exp_ph = '{0, 1, 3, 4, 6, 0, 0};
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            start_m = (c == 0);
            #1;
            check($sformatf("m c%0d phase", c), 32'(m_phase), 32'(exp_ph[c]));
            check($sformatf("m c%0d WEA",   c), 32'(m_wea),   32'(c == 1));
            check($sformatf("m c%0d WEB",   c), 32'(m_web),   32'(c == 2));
            check($sformatf("m c%0d IncB",  c), 32'(m_incb),  32'(c == 3));
            check($sformatf("m c%0d done",  c), 32'(m_done),  32'(c == 4));
            check($sformatf("m c%0d busy",  c), 32'(m_busy),  32'(c >= 1 && c <= 4));
            if (c >= 1) begin
                check($sformatf("m c%0d addr_a", c), 32'(m_addr_a), 32'(c >= 2));
                check($sformatf("m c%0d addr_b", c), 32'(m_addr_b), 32'(c >= 4));
            end
        end
        start_m = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
